// File: rtl/mor1kx_store_buffer_wc.sv
// In-order store buffer with first-word-fall-through head, occupancy count and per-byte
// store-to-load forwarding. Define STORE_BUFFER_COMBINE_EN to merge stores into the youngest entry.
module mor1kx_store_buffer_wc #(
  parameter int DEPTH_WIDTH          = 4,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic [OPTION_OPERAND_WIDTH-1:0]   pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_i,
  input  logic                              atomic_i,
  input  logic                              write_i,
  input  logic                              read_i,

  output logic [OPTION_OPERAND_WIDTH-1:0]   pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_o,
  output logic                              atomic_o,

  output logic                              full_o,
  output logic                              empty_o,
  output logic [DEPTH_WIDTH:0]              count_o,
  output logic                              combined_o,

  input  logic [OPTION_OPERAND_WIDTH-1:0]   lkup_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]   lkup_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] lkup_bsel_o
);

  localparam int OW    = OPTION_OPERAND_WIDTH;
  localparam int BW    = OW / 8;
  localparam int LSB   = (BW > 1) ? $clog2(BW) : 0;
  localparam int DEPTH = 1 << DEPTH_WIDTH;

  localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] ONE_CNT   = (DEPTH_WIDTH + 1)'(1);

  logic [OW-1:0] pc_q     [DEPTH];
  logic [OW-1:0] adr_q    [DEPTH];
  logic [OW-1:0] dat_q    [DEPTH];
  logic [BW-1:0] bsel_q   [DEPTH];
  logic          atomic_q [DEPTH];

  logic [DEPTH_WIDTH:0]   wr_ptr;
  logic [DEPTH_WIDTH:0]   rd_ptr;
  logic [DEPTH_WIDTH-1:0] wr_idx;
  logic [DEPTH_WIDTH-1:0] rd_idx;
  logic                   combine;
  logic                   push;
  logic                   pop;

  assign wr_idx  = wr_ptr[DEPTH_WIDTH-1:0];
  assign rd_idx  = rd_ptr[DEPTH_WIDTH-1:0];

  // The extra pointer bit distinguishes full from empty, so the difference is the occupancy.
  assign count_o = wr_ptr - rd_ptr;
  assign full_o  = (count_o == DEPTH_CNT);
  assign empty_o = (count_o == '0);

`ifdef STORE_BUFFER_COMBINE_EN
  logic [DEPTH_WIDTH-1:0] yng_idx;

  assign yng_idx = wr_idx - DEPTH_WIDTH'(1);

  // Merging into an entry that is leaving this cycle would lose the store, hence the count check.
  assign combine = write_i && !empty_o
                && (adr_q[yng_idx][OW-1:LSB] == adr_i[OW-1:LSB])
                && !atomic_i && !atomic_q[yng_idx]
                && !(read_i && (count_o == ONE_CNT));
`else
  assign combine = 1'b0;
`endif

  assign combined_o = combine;
  assign pop        = read_i && !empty_o;
  assign push       = write_i && !combine && (!full_o || read_i);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_CNT;
      if (pop)  rd_ptr <= rd_ptr + ONE_CNT;
    end
  end

  // NOTE: entry storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_idx]     <= pc_i;
      adr_q[wr_idx]    <= adr_i;
      dat_q[wr_idx]    <= dat_i;
      bsel_q[wr_idx]   <= bsel_i;
      atomic_q[wr_idx] <= atomic_i;
    end
`ifdef STORE_BUFFER_COMBINE_EN
    else if (combine) begin
      pc_q[yng_idx]   <= pc_i;
      bsel_q[yng_idx] <= bsel_q[yng_idx] | bsel_i;
      for (int b = 0; b < BW; b++) begin
        if (bsel_i[b]) dat_q[yng_idx][8*b +: 8] <= dat_i[8*b +: 8];
      end
    end
`endif
  end

  assign pc_o     = empty_o ? '0   : pc_q[rd_idx];
  assign adr_o    = empty_o ? '0   : adr_q[rd_idx];
  assign dat_o    = empty_o ? '0   : dat_q[rd_idx];
  assign bsel_o   = empty_o ? '0   : bsel_q[rd_idx];
  assign atomic_o = empty_o ? 1'b0 : atomic_q[rd_idx];

  logic [DEPTH_WIDTH-1:0] lk_idx;

  // Walk valid entries oldest to youngest so the youngest matching store wins each lane.
  // NOTE: every always_comb output gets a default first, which rules out inferred latches.
  always_comb begin
    lkup_dat_o  = '0;
    lkup_bsel_o = '0;
    lk_idx      = rd_idx;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = rd_idx + DEPTH_WIDTH'(k);
      if (((DEPTH_WIDTH + 1)'(k) < count_o)
          && (adr_q[lk_idx][OW-1:LSB] == lkup_adr_i[OW-1:LSB])) begin
        for (int b = 0; b < BW; b++) begin
          if (bsel_q[lk_idx][b]) begin
            lkup_dat_o[8*b +: 8] = dat_q[lk_idx][8*b +: 8];
            lkup_bsel_o[b]       = 1'b1;
          end
        end
      end
    end
  end

  generate
    if (LSB > 0) begin : g_lane_bits
      logic lkup_lane_unused;
      assign lkup_lane_unused = ^lkup_adr_i[LSB-1:0];
    end
  endgenerate

endmodule
